mc_control_fsm: RTL and testbench

- Main control sequencer for the multi-cycle RV32I core.
- Drives the write enables of the architectural state registers (PC, IR, register file, data memory) and the datapath mux/ALU selects, one state per cycle.
- Supports a memory ready handshake and counts retired instructions.
- Supported opcodes: lw, sw, R-type ALU, I-type ALU, beq, jal. Any other opcode traps.

---
 rtl/mc_control_fsm_pkg.sv | 83 ++++++++
 rtl/mc_control_fsm_alu_decoder.sv | 32 +++
 rtl/mc_control_fsm.sv | 179 +++++++++++++++++
 tb/tb_mc_control_fsm.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_control_fsm_pkg.sv
// Shared encodings for the multi-cycle RV32I control sequencer: state codes, opcodes,
// datapath mux selects, ALU op classes and the decoded control word.
package mc_control_fsm_pkg;

   localparam logic [3:0] S_FETCH    = 4'd0;
   localparam logic [3:0] S_DECODE   = 4'd1;
   localparam logic [3:0] S_MEMADR   = 4'd2;
   localparam logic [3:0] S_MEMREAD  = 4'd3;
   localparam logic [3:0] S_MEMWB    = 4'd4;
   localparam logic [3:0] S_MEMWRITE = 4'd5;
   localparam logic [3:0] S_EXECUTER = 4'd6;
   localparam logic [3:0] S_EXECUTEI = 4'd7;
   localparam logic [3:0] S_ALUWB    = 4'd8;
   localparam logic [3:0] S_BEQ      = 4'd9;
   localparam logic [3:0] S_JAL      = 4'd10;
   localparam logic [3:0] S_TRAP     = 4'd11;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   localparam logic       ADR_PC     = 1'b0;
   localparam logic       ADR_RESULT = 1'b1;

   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_DATA   = 2'b01;
   localparam logic [1:0] RES_ALURES = 2'b10;

   localparam logic [1:0] A_PC    = 2'b00;
   localparam logic [1:0] A_OLDPC = 2'b01;
   localparam logic [1:0] A_RS1   = 2'b10;

   localparam logic [1:0] B_RS2  = 2'b00;
   localparam logic [1:0] B_IMM  = 2'b01;
   localparam logic [1:0] B_FOUR = 2'b10;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   typedef struct packed {
      logic       adr_src;
      logic [1:0] result_src;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] aluop;
      logic       pc_update;
      logic       branch;
      logic       ir_write;
      logic       reg_write;
      logic       mem_write;
      logic       illegal;
   } ctrl_t;

   localparam ctrl_t CTRL_IDLE = '0;

   // Immediate format follows the opcode in every state so the datapath can pre-extend.
   function automatic logic [1:0] imm_src_of(input logic [6:0] opcode);
      logic [1:0] imm;
      case (opcode)
         OP_SW:   imm = IMM_S;
         OP_BEQ:  imm = IMM_B;
         OP_JAL:  imm = IMM_J;
         default: imm = IMM_I;
      endcase
      return imm;
   endfunction

endpackage

// File: rtl/mc_control_fsm_alu_decoder.sv
// Combinational ALU-op decode from op class, funct3, funct7[5] and op[5]; zero latency,
// no handshake. Unsupported funct3 values fall back to add rather than trapping.
module mc_control_fsm_alu_decoder
   import mc_control_fsm_pkg::*;
(
   input  logic [1:0] i_aluop,
   input  logic [2:0] i_funct3,
   input  logic       i_funct7b5,
   input  logic       i_op5,
   output logic [2:0] o_alu_control
);

   always_comb begin
      o_alu_control = ALU_ADD;
      case (i_aluop)
         ALUOP_ADD: o_alu_control = ALU_ADD;
         ALUOP_SUB: o_alu_control = ALU_SUB;
         ALUOP_FUNCT: begin
            case (i_funct3)
               // op[5] separates R-type sub from I-type addi, which has no subtract form
               3'b000:  o_alu_control = (i_funct7b5 & i_op5) ? ALU_SUB : ALU_ADD;
               3'b010:  o_alu_control = ALU_SLT;
               3'b110:  o_alu_control = ALU_OR;
               3'b111:  o_alu_control = ALU_AND;
               default: o_alu_control = ALU_ADD;
            endcase
         end
         default: o_alu_control = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle RV32I control sequencer: one state per cycle, Moore selects, enables zero in reset.
// mem_ready low stalls FETCH/MEMREAD/MEMWRITE indefinitely with all other outputs held stable.
module mc_control_fsm
   import mc_control_fsm_pkg::*;
#(
   parameter int unsigned INSTRET_W = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [6:0]           op,
   input  logic [2:0]           funct3,
   input  logic                 funct7b5,
   input  logic                 zero,
   input  logic                 mem_ready,
   output logic                 pc_write,
   output logic                 ir_write,
   output logic                 reg_write,
   output logic                 mem_write,
   output logic                 adr_src,
   output logic [1:0]           result_src,
   output logic [1:0]           alu_src_a,
   output logic [1:0]           alu_src_b,
   output logic [1:0]           imm_src,
   output logic [2:0]           alu_control,
   output logic                 retire,
   output logic [INSTRET_W-1:0] instret,
   output logic                 illegal
);

   localparam logic [INSTRET_W-1:0] INSTRET_ONE = {{(INSTRET_W-1){1'b0}}, 1'b1};

   logic [3:0]           r_state;
   logic [3:0]           w_next;
   logic [INSTRET_W-1:0] r_instret;
   ctrl_t                w_ctrl;
   logic                 w_retire;

   always_comb begin
      w_next = S_FETCH;
      case (r_state)
         S_FETCH:    w_next = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW: w_next = S_MEMADR;
               OP_R:         w_next = S_EXECUTER;
               OP_I:         w_next = S_EXECUTEI;
               OP_BEQ:       w_next = S_BEQ;
               OP_JAL:       w_next = S_JAL;
               default:      w_next = S_TRAP;
            endcase
         end
         S_MEMADR:   w_next = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD:  w_next = mem_ready ? S_MEMWB : S_MEMREAD;
         S_MEMWB:    w_next = S_FETCH;
         S_MEMWRITE: w_next = mem_ready ? S_FETCH : S_MEMWRITE;
         S_EXECUTER: w_next = S_ALUWB;
         S_EXECUTEI: w_next = S_ALUWB;
         S_ALUWB:    w_next = S_FETCH;
         S_BEQ:      w_next = S_FETCH;
         S_JAL:      w_next = S_ALUWB;
         S_TRAP:     w_next = S_TRAP;
         // unused encodings recover through the FETCH default
         default:    w_next = S_FETCH;
      endcase
   end

   always_comb begin
      w_ctrl = CTRL_IDLE;
      case (r_state)
         S_FETCH: begin
            w_ctrl.adr_src    = ADR_PC;
            w_ctrl.alu_src_a  = A_PC;
            w_ctrl.alu_src_b  = B_FOUR;
            w_ctrl.aluop      = ALUOP_ADD;
            w_ctrl.result_src = RES_ALURES;
            w_ctrl.ir_write   = mem_ready;
            w_ctrl.pc_update  = mem_ready;
         end
         S_DECODE: begin
            w_ctrl.alu_src_a = A_OLDPC;
            w_ctrl.alu_src_b = B_IMM;
            w_ctrl.aluop     = ALUOP_ADD;
         end
         S_MEMADR: begin
            w_ctrl.alu_src_a = A_RS1;
            w_ctrl.alu_src_b = B_IMM;
            w_ctrl.aluop     = ALUOP_ADD;
         end
         S_MEMREAD: begin
            w_ctrl.adr_src    = ADR_RESULT;
            w_ctrl.result_src = RES_ALUOUT;
         end
         S_MEMWB: begin
            w_ctrl.result_src = RES_DATA;
            w_ctrl.reg_write  = 1'b1;
         end
         S_MEMWRITE: begin
            w_ctrl.adr_src    = ADR_RESULT;
            w_ctrl.result_src = RES_ALUOUT;
            w_ctrl.mem_write  = 1'b1;
         end
         S_EXECUTER: begin
            w_ctrl.alu_src_a = A_RS1;
            w_ctrl.alu_src_b = B_RS2;
            w_ctrl.aluop     = ALUOP_FUNCT;
         end
         S_EXECUTEI: begin
            w_ctrl.alu_src_a = A_RS1;
            w_ctrl.alu_src_b = B_IMM;
            w_ctrl.aluop     = ALUOP_FUNCT;
         end
         S_ALUWB: begin
            w_ctrl.result_src = RES_ALUOUT;
            w_ctrl.reg_write  = 1'b1;
         end
         S_BEQ: begin
            w_ctrl.alu_src_a  = A_RS1;
            w_ctrl.alu_src_b  = B_RS2;
            w_ctrl.aluop      = ALUOP_SUB;
            w_ctrl.result_src = RES_ALUOUT;
            w_ctrl.branch     = 1'b1;
         end
         S_JAL: begin
            w_ctrl.alu_src_a  = A_OLDPC;
            w_ctrl.alu_src_b  = B_FOUR;
            w_ctrl.aluop      = ALUOP_ADD;
            w_ctrl.result_src = RES_ALUOUT;
            w_ctrl.pc_update  = 1'b1;
         end
         S_TRAP:  w_ctrl.illegal = 1'b1;
         default: w_ctrl = CTRL_IDLE;
      endcase
   end

   // Retire exactly on the edges that return to FETCH after a completed instruction.
   always_comb begin
      w_retire = 1'b0;
      case (r_state)
         S_MEMWB, S_ALUWB, S_BEQ: w_retire = 1'b1;
         S_MEMWRITE:              w_retire = mem_ready;
         default:                 w_retire = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= S_FETCH;
         r_instret <= '0;
      end else begin
         r_state <= w_next;
         if (w_retire) begin
            r_instret <= r_instret + INSTRET_ONE;
         end
      end
   end

   mc_control_fsm_alu_decoder u_alu_decoder (
      .i_aluop       (w_ctrl.aluop),
      .i_funct3      (funct3),
      .i_funct7b5    (funct7b5),
      .i_op5         (op[5]),
      .o_alu_control (alu_control)
   );

   // Reset is folded into every enable so the async-reset FETCH state cannot write.
   assign pc_write   = rst & (w_ctrl.pc_update | (w_ctrl.branch & zero));
   assign ir_write   = rst & w_ctrl.ir_write;
   assign reg_write  = rst & w_ctrl.reg_write;
   assign mem_write  = rst & w_ctrl.mem_write;
   assign retire     = rst & w_retire;
   assign illegal    = rst & w_ctrl.illegal;
   assign adr_src    = w_ctrl.adr_src;
   assign result_src = w_ctrl.result_src;
   assign alu_src_a  = w_ctrl.alu_src_a;
   assign alu_src_b  = w_ctrl.alu_src_b;
   assign imm_src    = imm_src_of(op);
   assign instret    = r_instret;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm; output word = {pc_w, ir_w, reg_w, mem_w, adr, res, a, b, imm, alu, retire, illegal}.
// A second instance with a 3-bit instret exercises counter wrap in a short run.
module tb_mc_control_fsm;

   localparam logic [6:0] T_LW  = 7'b0000011;
   localparam logic [6:0] T_SW  = 7'b0100011;
   localparam logic [6:0] T_R   = 7'b0110011;
   localparam logic [6:0] T_I   = 7'b0010011;
   localparam logic [6:0] T_BEQ = 7'b1100011;
   localparam logic [6:0] T_JAL = 7'b1101111;
   localparam logic [6:0] T_BAD = 7'b1111111;

   logic        clk = 1'b0;
   logic        rst;
   logic [6:0]  op;
   logic [2:0]  funct3;
   logic        funct7b5;
   logic        zero;
   logic        mem_ready;

   logic        pc_write, ir_write, reg_write, mem_write, adr_src, retire, illegal;
   logic [1:0]  result_src, alu_src_a, alu_src_b, imm_src;
   logic [2:0]  alu_control;
   logic [31:0] instret;

   logic        pc_write_s, ir_write_s, reg_write_s, mem_write_s, adr_src_s, retire_s, illegal_s;
   logic [1:0]  result_src_s, alu_src_a_s, alu_src_b_s, imm_src_s;
   logic [2:0]  alu_control_s;
   logic [2:0]  instret_s;

   logic [17:0] obs, obs_s;
   logic [31:0] exp_instret;
   int          checks = 0;
   int          errors = 0;

   assign obs   = {pc_write, ir_write, reg_write, mem_write, adr_src, result_src,
                   alu_src_a, alu_src_b, imm_src, alu_control, retire, illegal};
   assign obs_s = {pc_write_s, ir_write_s, reg_write_s, mem_write_s, adr_src_s, result_src_s,
                   alu_src_a_s, alu_src_b_s, imm_src_s, alu_control_s, retire_s, illegal_s};

   always #5 clk = ~clk;

   mc_control_fsm #(.INSTRET_W(32)) dut (
      .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
      .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write), .reg_write(reg_write),
      .mem_write(mem_write), .adr_src(adr_src), .result_src(result_src), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .imm_src(imm_src), .alu_control(alu_control), .retire(retire),
      .instret(instret), .illegal(illegal)
   );

   mc_control_fsm #(.INSTRET_W(3)) dut_s (
      .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
      .mem_ready(mem_ready), .pc_write(pc_write_s), .ir_write(ir_write_s), .reg_write(reg_write_s),
      .mem_write(mem_write_s), .adr_src(adr_src_s), .result_src(result_src_s), .alu_src_a(alu_src_a_s),
      .alu_src_b(alu_src_b_s), .imm_src(imm_src_s), .alu_control(alu_control_s), .retire(retire_s),
      .instret(instret_s), .illegal(illegal_s)
   );

   task automatic test_reset();
      rst = 1'b1; op = T_R; funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b0; mem_ready = 1'b1;
      #1 rst = 1'b0;
      #1;
      checks++;
      if (obs !== 18'b0_0_0_0_0_10_00_10_00_000_0_0) begin
         errors++; $display("FAIL reset_outputs: got %b want %b", obs, 18'b0_0_0_0_0_10_00_10_00_000_0_0);
      end
      checks++;
      if (instret !== 32'd0) begin errors++; $display("FAIL reset_instret: got %0d want 0", instret); end
      @(posedge clk); #1;
      checks++;
      if (obs !== 18'b0_0_0_0_0_10_00_10_00_000_0_0) begin
         errors++; $display("FAIL reset_held: got %b want %b", obs, 18'b0_0_0_0_0_10_00_10_00_000_0_0);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      exp_instret = 32'd0;
   endtask

   task automatic test_lw();
      logic [17:0] exp_w [0:4];
      exp_w = '{18'b1_1_0_0_0_10_00_10_00_000_0_0, 18'b0_0_0_0_0_00_01_01_00_000_0_0,
                18'b0_0_0_0_0_00_10_01_00_000_0_0, 18'b0_0_0_0_1_00_00_00_00_000_0_0,
                18'b0_0_1_0_0_01_00_00_00_000_1_0};
      op = T_LW; mem_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         #1;
         checks++;
         if (obs !== exp_w[k]) begin errors++; $display("FAIL lw_cyc%0d: got %b want %b", k, obs, exp_w[k]); end
         @(posedge clk); #1;
      end
      exp_instret = exp_instret + 32'd1;
      checks++;
      if (instret !== exp_instret) begin errors++; $display("FAIL lw_instret: got %0d want %0d", instret, exp_instret); end
   endtask

   task automatic test_sw_stall();
      logic [17:0] exp_w [0:6];
      logic        mr [0:6];
      exp_w = '{18'b1_1_0_0_0_10_00_10_01_000_0_0, 18'b0_0_0_0_0_00_01_01_01_000_0_0,
                18'b0_0_0_0_0_00_10_01_01_000_0_0, 18'b0_0_0_1_1_00_00_00_01_000_0_0,
                18'b0_0_0_1_1_00_00_00_01_000_0_0, 18'b0_0_0_1_1_00_00_00_01_000_0_0,
                18'b0_0_0_1_1_00_00_00_01_000_1_0};
      mr = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      op = T_SW;
      for (int k = 0; k < 7; k++) begin
         mem_ready = mr[k];
         #1;
         checks++;
         if (obs !== exp_w[k]) begin errors++; $display("FAIL sw_cyc%0d: got %b want %b", k, obs, exp_w[k]); end
         @(posedge clk); #1;
      end
      exp_instret = exp_instret + 32'd1;
      checks++;
      if (instret !== exp_instret) begin errors++; $display("FAIL sw_instret: got %0d want %0d", instret, exp_instret); end
      // back in FETCH with memory not ready: enables must stay low and the state must hold
      mem_ready = 1'b0;
      for (int k = 0; k < 2; k++) begin
         #1;
         checks++;
         if (obs !== 18'b0_0_0_0_0_10_00_10_01_000_0_0) begin
            errors++; $display("FAIL fetch_stall%0d: got %b want %b", k, obs, 18'b0_0_0_0_0_10_00_10_01_000_0_0);
         end
         @(posedge clk); #1;
      end
      mem_ready = 1'b1;
   endtask

   task automatic test_alu_decode();
      logic [6:0]  ops  [0:5];
      logic [2:0]  f3   [0:5];
      logic        f7   [0:5];
      logic [17:0] exec [0:5];
      ops  = '{T_R, T_I, T_R, T_R, T_R, T_R};
      f3   = '{3'b000, 3'b000, 3'b111, 3'b110, 3'b010, 3'b001};
      f7   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      exec = '{18'b0_0_0_0_0_00_10_00_00_001_0_0, 18'b0_0_0_0_0_00_10_01_00_000_0_0,
               18'b0_0_0_0_0_00_10_00_00_010_0_0, 18'b0_0_0_0_0_00_10_00_00_011_0_0,
               18'b0_0_0_0_0_00_10_00_00_101_0_0, 18'b0_0_0_0_0_00_10_00_00_000_0_0};
      mem_ready = 1'b1;
      for (int n = 0; n < 6; n++) begin
         op = ops[n]; funct3 = f3[n]; funct7b5 = f7[n];
         @(posedge clk); #1;
         @(posedge clk); #1;
         checks++;
         if (obs !== exec[n]) begin errors++; $display("FAIL alu_exec%0d: got %b want %b", n, obs, exec[n]); end
         @(posedge clk); #1;
         checks++;
         if (obs !== 18'b0_0_1_0_0_00_00_00_00_000_1_0) begin
            errors++; $display("FAIL alu_wb%0d: got %b want %b", n, obs, 18'b0_0_1_0_0_00_00_00_00_000_1_0);
         end
         @(posedge clk); #1;
         exp_instret = exp_instret + 32'd1;
      end
      funct7b5 = 1'b0; funct3 = 3'b000;
      checks++;
      if (instret !== exp_instret) begin errors++; $display("FAIL alu_instret: got %0d want %0d", instret, exp_instret); end
   endtask

   task automatic test_beq();
      logic [17:0] exp_b [0:1];
      exp_b = '{18'b1_0_0_0_0_00_10_00_10_001_1_0, 18'b0_0_0_0_0_00_10_00_10_001_1_0};
      op = T_BEQ; mem_ready = 1'b1;
      for (int n = 0; n < 2; n++) begin
         zero = (n == 0);
         #1;
         checks++;
         if (obs !== 18'b1_1_0_0_0_10_00_10_10_000_0_0) begin
            errors++; $display("FAIL beq_fetch%0d: got %b want %b", n, obs, 18'b1_1_0_0_0_10_00_10_10_000_0_0);
         end
         @(posedge clk); #1;
         checks++;
         if (obs !== 18'b0_0_0_0_0_00_01_01_10_000_0_0) begin
            errors++; $display("FAIL beq_decode%0d: got %b want %b", n, obs, 18'b0_0_0_0_0_00_01_01_10_000_0_0);
         end
         @(posedge clk); #1;
         checks++;
         if (obs !== exp_b[n]) begin errors++; $display("FAIL beq_exec%0d: got %b want %b", n, obs, exp_b[n]); end
         @(posedge clk); #1;
         exp_instret = exp_instret + 32'd1;
      end
      zero = 1'b0;
      checks++;
      if (instret !== exp_instret) begin errors++; $display("FAIL beq_instret: got %0d want %0d", instret, exp_instret); end
   endtask

   task automatic test_jal();
      logic [17:0] exp_w [0:3];
      exp_w = '{18'b1_1_0_0_0_10_00_10_11_000_0_0, 18'b0_0_0_0_0_00_01_01_11_000_0_0,
                18'b1_0_0_0_0_00_01_10_11_000_0_0, 18'b0_0_1_0_0_00_00_00_11_000_1_0};
      op = T_JAL; mem_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
         checks++;
         if (obs !== exp_w[k]) begin errors++; $display("FAIL jal_cyc%0d: got %b want %b", k, obs, exp_w[k]); end
         @(posedge clk); #1;
      end
      exp_instret = exp_instret + 32'd1;
      checks++;
      if (instret !== exp_instret) begin errors++; $display("FAIL jal_instret: got %0d want %0d", instret, exp_instret); end
   endtask

   task automatic test_trap();
      int bad = 0;
      op = T_BAD; mem_ready = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      for (int k = 0; k < 20; k++) begin
         zero = k[0]; mem_ready = ~k[1];
         #1;
         if (obs !== 18'b0_0_0_0_0_00_00_00_00_000_0_1) bad++;
         @(posedge clk); #1;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL trap_hold: got %0d bad cycles want 0", bad); end
      checks++;
      if (instret !== exp_instret) begin errors++; $display("FAIL trap_instret: got %0d want %0d", instret, exp_instret); end
      #2 rst = 1'b0;
      #1;
      checks++;
      if (obs !== 18'b0_0_0_0_0_10_00_10_00_000_0_0) begin
         errors++; $display("FAIL trap_reset: got %b want %b", obs, 18'b0_0_0_0_0_10_00_10_00_000_0_0);
      end
      @(posedge clk); #1;
      rst = 1'b1; mem_ready = 1'b1; zero = 1'b0; op = T_R;
      exp_instret = 32'd0;
      #1;
      checks++;
      if (obs !== 18'b1_1_0_0_0_10_00_10_00_000_0_0) begin
         errors++; $display("FAIL trap_refetch: got %b want %b", obs, 18'b1_1_0_0_0_10_00_10_00_000_0_0);
      end
      checks++;
      if (instret !== 32'd0) begin errors++; $display("FAIL trap_instret_clr: got %0d want 0", instret); end
   endtask

   task automatic test_reset_mid_stall();
      // one instruction first so the clear to zero is observable
      op = T_JAL; mem_ready = 1'b1;
      repeat (4) begin @(posedge clk); #1; end
      op = T_LW;
      repeat (3) begin @(posedge clk); #1; end
      mem_ready = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      checks++;
      if (obs !== 18'b0_0_0_0_1_00_00_00_00_000_0_0) begin
         errors++; $display("FAIL stall_memread: got %b want %b", obs, 18'b0_0_0_0_1_00_00_00_00_000_0_0);
      end
      checks++;
      if (instret !== 32'd1) begin errors++; $display("FAIL stall_instret: got %0d want 1", instret); end
      #2 rst = 1'b0;
      #1;
      checks++;
      if (obs !== 18'b0_0_0_0_0_10_00_10_00_000_0_0) begin
         errors++; $display("FAIL midreset_out: got %b want %b", obs, 18'b0_0_0_0_0_10_00_10_00_000_0_0);
      end
      checks++;
      if (instret !== 32'd0 || instret_s !== 3'd0) begin
         errors++; $display("FAIL midreset_instret: got %0d/%0d want 0/0", instret, instret_s);
      end
      @(posedge clk); #1;
      rst = 1'b1; mem_ready = 1'b1; op = T_R;
      exp_instret = 32'd0;
   endtask

   task automatic test_wrap();
      logic [17:0] exp_w [0:3];
      logic [2:0]  exp_small;
      exp_w = '{18'b1_1_0_0_0_10_00_10_00_000_0_0, 18'b0_0_0_0_0_00_01_01_00_000_0_0,
                18'b0_0_0_0_0_00_10_00_00_000_0_0, 18'b0_0_1_0_0_00_00_00_00_000_1_0};
      op = T_R; funct3 = 3'b000; funct7b5 = 1'b0; mem_ready = 1'b1;
      exp_small = 3'd0;
      for (int i = 0; i < 8; i++) begin
         for (int k = 0; k < 4; k++) begin
            #1;
            checks++;
            if (obs_s !== exp_w[k]) begin errors++; $display("FAIL wrap_i%0d_cyc%0d: got %b want %b", i, k, obs_s, exp_w[k]); end
            @(posedge clk); #1;
         end
         exp_instret = exp_instret + 32'd1;
         exp_small   = exp_small + 3'd1;
         checks++;
         if (instret !== exp_instret) begin errors++; $display("FAIL wrap_wide%0d: got %0d want %0d", i, instret, exp_instret); end
         checks++;
         if (instret_s !== exp_small) begin errors++; $display("FAIL wrap_small%0d: got %0d want %0d", i, instret_s, exp_small); end
      end
   endtask

   initial begin
      test_reset();
      test_lw();
      test_sw_stall();
      test_alu_decode();
      test_beq();
      test_jal();
      test_trap();
      test_reset_mid_stall();
      test_wrap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
